// File: rtl/hcu_pkg.sv
// rtl/hcu_pkg.sv - shared encodings for the hazard control unit
package hcu_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_BR_FLUSH = 2'b10,
        ST_MEM_WAIT = 2'b11
    } hcu_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline-to-HCU signal bundle (HCU_PERF_CNT_EN adds counters)
interface hazard_control_unit_if;
    logic [3:0]  id_rn, id_rm, id_rd;
    logic        id_use_rn, id_use_rm, id_use_rd;
    logic [3:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_rf_enable, mem_rf_enable, wb_rf_enable;
    logic        ex_load_instr;
    logic        id_branch_taken;
    logic        mem_busy;
    logic        pc_le, if_id_le;
    logic        nop_sel;
    logic        if_id_clr;
    logic        pipe_freeze;
    logic [1:0]  fwd_a, fwd_b, fwd_d;
    logic [1:0]  hcu_state;
`ifdef HCU_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    modport master (
        output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
        output ex_rd, mem_rd, wb_rd, ex_rf_enable, mem_rf_enable, wb_rf_enable,
        output ex_load_instr, id_branch_taken, mem_busy,
        input  pc_le, if_id_le, nop_sel, if_id_clr, pipe_freeze,
        input  fwd_a, fwd_b, fwd_d, hcu_state
`ifdef HCU_PERF_CNT_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
        input  ex_rd, mem_rd, wb_rd, ex_rf_enable, mem_rf_enable, wb_rf_enable,
        input  ex_load_instr, id_branch_taken, mem_busy,
        output pc_le, if_id_le, nop_sel, if_id_clr, pipe_freeze,
        output fwd_a, fwd_b, fwd_d, hcu_state
`ifdef HCU_PERF_CNT_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-operand forwarding source select, EX > MEM > WB
module fwd_select
    import hcu_pkg::*;
(
    input  logic [3:0] src,
    input  logic [3:0] ex_rd,
    input  logic [3:0] mem_rd,
    input  logic [3:0] wb_rd,
    input  logic       ex_fwd_ok,
    input  logic       mem_rf_enable,
    input  logic       wb_rf_enable,
    output fwd_sel_e   sel
);
    always_comb begin
        sel = FWD_RF;
        // The PC is never forwarded; the datapath supplies it directly.
        if (src != PC_REG) begin
            if (ex_fwd_ok && ex_rd == src)
                sel = FWD_EX;
            else if (mem_rf_enable && mem_rd == src)
                sel = FWD_MEM;
            else if (wb_rf_enable && wb_rd == src)
                sel = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush/freeze FSM and forwarding; HCU_PERF_CNT_EN adds stall/flush counters
module hazard_control_unit
    import hcu_pkg::*;
(
    input  logic                   clk,
    input  logic                   clr_n,
    hazard_control_unit_if.slave   hcu
);
    hcu_state_e state, state_next;
    hcu_state_e saved, saved_next;
    logic       active;
    logic       load_use;
    logic       stall_entry, flush_entry;
    logic       pc_le_c, if_id_le_c, nop_sel_c, if_id_clr_c, freeze_c;
    fwd_sel_e   sel_a, sel_b, sel_d;
    logic       ex_fwd_ok;

    assign load_use = hcu.ex_load_instr && hcu.ex_rf_enable &&
                      ((hcu.id_use_rn && hcu.ex_rd == hcu.id_rn) ||
                       (hcu.id_use_rm && hcu.ex_rd == hcu.id_rm) ||
                       (hcu.id_use_rd && hcu.ex_rd == hcu.id_rd));

    assign ex_fwd_ok = hcu.ex_rf_enable && !hcu.ex_load_instr;

    fwd_select u_fwd_a (.src(hcu.id_rn), .ex_rd(hcu.ex_rd), .mem_rd(hcu.mem_rd), .wb_rd(hcu.wb_rd),
                        .ex_fwd_ok(ex_fwd_ok), .mem_rf_enable(hcu.mem_rf_enable),
                        .wb_rf_enable(hcu.wb_rf_enable), .sel(sel_a));
    fwd_select u_fwd_b (.src(hcu.id_rm), .ex_rd(hcu.ex_rd), .mem_rd(hcu.mem_rd), .wb_rd(hcu.wb_rd),
                        .ex_fwd_ok(ex_fwd_ok), .mem_rf_enable(hcu.mem_rf_enable),
                        .wb_rf_enable(hcu.wb_rf_enable), .sel(sel_b));
    fwd_select u_fwd_d (.src(hcu.id_rd), .ex_rd(hcu.ex_rd), .mem_rd(hcu.mem_rd), .wb_rd(hcu.wb_rd),
                        .ex_fwd_ok(ex_fwd_ok), .mem_rf_enable(hcu.mem_rf_enable),
                        .wb_rf_enable(hcu.wb_rf_enable), .sel(sel_d));

    // 'active' holds reset-value outputs until the first clock edge after clr_n releases.
    always_comb begin
        state_next  = state;
        saved_next  = saved;
        pc_le_c     = 1'b1;
        if_id_le_c  = 1'b1;
        nop_sel_c   = 1'b0;
        if_id_clr_c = 1'b0;
        freeze_c    = 1'b0;
        stall_entry = 1'b0;
        flush_entry = 1'b0;
        if (!active) begin
            pc_le_c     = 1'b0;
            if_id_le_c  = 1'b0;
            nop_sel_c   = 1'b1;
            if_id_clr_c = 1'b1;
            state_next  = ST_RUN;
            saved_next  = ST_RUN;
        end else if (hcu.mem_busy) begin
            freeze_c   = 1'b1;
            pc_le_c    = 1'b0;
            if_id_le_c = 1'b0;
            if (state != ST_MEM_WAIT) begin
                saved_next = state;
                state_next = ST_MEM_WAIT;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (load_use) begin
                        pc_le_c     = 1'b0;
                        if_id_le_c  = 1'b0;
                        nop_sel_c   = 1'b1;
                        state_next  = ST_LD_STALL;
                        stall_entry = 1'b1;
                    end else if (hcu.id_branch_taken) begin
                        if_id_clr_c = 1'b1;
                        state_next  = ST_BR_FLUSH;
                        flush_entry = 1'b1;
                    end
                end
                ST_LD_STALL, ST_BR_FLUSH: state_next = ST_RUN;
                ST_MEM_WAIT: begin
                    // Release cycle: back end restarts, front end holds with a bubble into ID/EX.
                    pc_le_c    = 1'b0;
                    if_id_le_c = 1'b0;
                    nop_sel_c  = 1'b1;
                    state_next = saved;
                    saved_next = ST_RUN;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= ST_RUN;
            saved  <= ST_RUN;
            active <= 1'b0;
        end else begin
            state  <= state_next;
            saved  <= saved_next;
            active <= 1'b1;
        end
    end

    assign hcu.pc_le       = pc_le_c;
    assign hcu.if_id_le    = if_id_le_c;
    assign hcu.nop_sel     = nop_sel_c;
    assign hcu.if_id_clr   = if_id_clr_c;
    assign hcu.pipe_freeze = freeze_c;
    assign hcu.hcu_state   = state;
    assign hcu.fwd_a       = active ? sel_a : FWD_RF;
    assign hcu.fwd_b       = active ? sel_b : FWD_RF;
    assign hcu.fwd_d       = active ? sel_d : FWD_RF;

`ifdef HCU_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stall_cnt <= 16'h0000;
            flush_cnt <= 16'h0000;
        end else begin
            if (stall_entry && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'h0001;
            if (flush_entry && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'h0001;
        end
    end

    assign hcu.stall_cnt = stall_cnt;
    assign hcu.flush_cnt = flush_cnt;
`else
    logic unused_entry;
    assign unused_entry = stall_entry ^ flush_entry;
`endif
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have port clk, input, 1, pipeline clock; all state updates on posedge.
REQ-002 SHALL have port clr_n, input, 1, reset; reset is asynchronous and active-low.
REQ-003 SHALL have ports id_rn, id_rm, id_rd, input, 4 each, ID-stage source registers (Rn = I19_16, Rm = I3_0, store data = I15_12).
REQ-004 SHALL have ports id_use_rn, id_use_rm, id_use_rd, input, 1 each, source actually read by the ID instruction.
REQ-005 SHALL have ports ex_rd, mem_rd, wb_rd, input, 4 each, destination registers in EX, MEM and WB.
REQ-006 SHALL have ports ex_rf_enable, mem_rf_enable, wb_rf_enable, input, 1 each, write-back pending per stage.
REQ-007 SHALL have port ex_load_instr, input, 1, EX instruction is a load.
REQ-008 SHALL have port id_branch_taken, input, 1, B/BL in ID with condition true.
REQ-009 SHALL have port mem_busy, input, 1, data memory not ready.
REQ-010 SHALL have outputs pc_le, if_id_le, 1 each, load enables for PC and IF/ID.
REQ-011 SHALL have output nop_sel, 1, drives CU NOP mux select (1 = insert NOP into ID/EX).
REQ-012 SHALL have output if_id_clr, 1, flushes IF/ID.
REQ-013 SHALL have output pipe_freeze, 1, holds ID/EX, EX/MEM and MEM/WB.
REQ-014 SHALL have outputs fwd_a, fwd_b, fwd_d, 2 each, operand source: 00 register file, 01 EX, 10 MEM, 11 WB.
REQ-015 SHALL have output hcu_state, 2, current FSM state for debug.

Function
REQ-016 SHALL implement FSM states RUN=00, LD_STALL=01, BR_FLUSH=10, MEM_WAIT=11.
REQ-017 SHALL detect load-use when ex_load_instr & ex_rf_enable & ex_rd equals any used ID source; in RUN: pc_le=0, if_id_le=0, nop_sel=1; next state LD_STALL.
REQ-018 SHALL in LD_STALL drive pc_le=1, if_id_le=1, nop_sel=0 and return to RUN after exactly one cycle (one-bubble latency).
REQ-019 SHALL on id_branch_taken in RUN (no load-use) assert if_id_clr=1 for that cycle, keep pc_le=1, and go to BR_FLUSH.
REQ-020 SHALL in BR_FLUSH ignore id_branch_taken (flushed slot) and return to RUN after one cycle.
REQ-021 SHALL give load-use priority over branch taken in the same cycle; the branch is re-evaluated in the cycle after LD_STALL.
REQ-022 SHALL, when mem_busy=1 in any state, drive pipe_freeze=1, pc_le=0, if_id_le=0, if_id_clr=0 and enter MEM_WAIT, saving the interrupted state.
REQ-023 SHALL hold MEM_WAIT while mem_busy=1; on deassertion resume the saved state, or RUN if the saved state was RUN.
REQ-024 SHALL select forwarding combinationally with priority EX > MEM > WB; a stage matches only if its rf_enable=1 and rd equals the source.
REQ-025 SHALL never forward from EX when that instruction is a load (stall covers it).
REQ-026 SHALL never forward register 15 (PC); fwd_x=00 when the source is 15.
REQ-027 SHALL in RUN with no hazard drive pc_le=1, if_id_le=1, nop_sel=0, if_id_clr=0, pipe_freeze=0.

Reset
REQ-028 SHALL on clr_n=0 immediately force state RUN, saved state RUN, pc_le=0, if_id_le=0, nop_sel=1, if_id_clr=1, pipe_freeze=0, fwd_*=00, and clear any counters.
REQ-029 SHALL resume normal RUN outputs on the first posedge after clr_n rises; reset mid-stall or mid-wait discards the pending state.

Configuration
REQ-030 SHALL with HCU_PERF_CNT_EN defined add outputs stall_cnt[15:0] and flush_cnt[15:0], incremented on LD_STALL entry and BR_FLUSH entry, saturating at 0xFFFF.
REQ-031 SHALL without HCU_PERF_CNT_EN omit those ports and registers entirely.

Structure
REQ-032 SHALL place FSM state encodings, forwarding-select encodings and the PC register index (15) in shared package hcu_pkg.
REQ-033 SHALL implement forwarding as one sub-module fwd_select, instantiated three times (A, B, D).

Verification
REQ-034 SHALL cover: LDR R1 in EX (ex_rd=1, load), ID uses Rn=1 -> one cycle pc_le=0, nop_sel=1, state 01, then RUN with fwd_a=10.
REQ-035 SHALL cover: ADD R2 in EX, ADD R2 in WB, ID Rm=2 -> fwd_b=01 (EX wins); EX rf_enable=0 -> fwd_b=11.
REQ-036 SHALL cover: id_branch_taken=1 in RUN -> if_id_clr=1 one cycle, state 10, then 00.
REQ-037 SHALL cover: load-use and branch in the same cycle -> LD_STALL first, if_id_clr=0 that cycle.
REQ-038 SHALL cover: mem_busy high 3 cycles during LD_STALL -> pipe_freeze=1 for 3 cycles, state 11, then LD_STALL resumes.
REQ-039 SHALL cover: clr_n low mid-MEM_WAIT -> outputs reset asynchronously, state 00; source 15 -> fwd_*=00.
